// File: rtl/npu_inst_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : npu_inst_seq
// Description : Instruction sequencer for the single-core NPU. One start
//               pulse runs one attention-tile pass on the 20-bit inst bus:
//               K/Q SRAM fill from an external source, kernel load, Q
//               streaming, OFIFO drain into psum SRAM, SFP accumulate and
//               SFP divide with write-back.
//
// Ports       : clk       - clock
//               reset     - synchronous reset, active low
//               start     - one-cycle start pulse, ignored while busy
//               n_k       - K row count minus 1, sampled on accepted start
//               n_q       - Q row count minus 1, sampled on accepted start
//               in_valid  - external source presents a mem_in word
//               in_ready  - word consumed this cycle (mirrors kmem/qmem wr)
//               inst      - registered core instruction word
//               busy      - high from the cycle after start until done
//               done      - one-cycle pulse on the last cycle of the pass
//
// inst map    : 19 sfp_wr2pmem, 18 sfp_div, 17 sfp_acc, 16 ofifo_rd,
//               15:12 qkmem_add, 11:8 pmem_add, 7 mac execute,
//               6 mac kernel-load, 5 qmem_rd, 4 qmem_wr, 3 kmem_rd,
//               2 kmem_wr, 1 pmem_rd, 0 pmem_wr
//
// Revision    : 1.0 - initial release
// ============================================================================
module npu_inst_seq #(
    parameter int ADDR_W = 4,   // SRAM address width, at most 4 (inst field width)
    parameter int DRAIN  = 16   // settle cycles between last execute and first OFIFO read
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] n_k,
    input  logic [ADDR_W-1:0] n_q,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [19:0]       inst,
    output logic              busy,
    output logic              done
);

    // ------------------------------------------------------------------------
    // Instruction bit positions
    // ------------------------------------------------------------------------
    localparam int B_SFP_WR2PMEM = 19;
    localparam int B_SFP_DIV     = 18;
    localparam int B_SFP_ACC     = 17;
    localparam int B_OFIFO_RD    = 16;
    localparam int B_QK_ADD      = 12;
    localparam int B_P_ADD       = 8;
    localparam int B_EXECUTE     = 7;
    localparam int B_LOAD        = 6;
    localparam int B_QMEM_RD     = 5;
    localparam int B_QMEM_WR     = 4;
    localparam int B_KMEM_RD     = 3;
    localparam int B_KMEM_WR     = 2;
    localparam int B_PMEM_RD     = 1;
    localparam int B_PMEM_WR     = 0;

    // The cycle counter must reach N (= 2**ADDR_W for the lag cycle) and
    // DRAIN-1, so it is one bit wider than an address at minimum.
    localparam int DRAIN_CW = $clog2(DRAIN + 1);
    localparam int CNT_W    = (ADDR_W + 1 > DRAIN_CW) ? ADDR_W + 1 : DRAIN_CW;

    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_WR_K  = 4'd1,
        S_WR_Q  = 4'd2,
        S_LD_K  = 4'd3,
        S_EXE   = 4'd4,
        S_DRAIN = 4'd5,
        S_OF    = 4'd6,
        S_ACC   = 4'd7,
        S_DIV   = 4'd8,
        S_FIN   = 4'd9
    } state_t;

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [1:0]          phase_q,    phase_d;
    logic [ADDR_W-1:0]   nk_q,       nk_d;
    logic [ADDR_W-1:0]   nq_q,       nq_d;
    logic [19:0]         inst_q,     inst_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;

    // Derived counts: *_last is the final address (N-1), *_rows is N, which
    // is also the index of the lag cycle that closes each streaming phase.
    logic [CNT_W-1:0]    nk_last;
    logic [CNT_W-1:0]    nq_last;
    logic [CNT_W-1:0]    nk_rows;
    logic [CNT_W-1:0]    nq_rows;
    logic [ADDR_W-1:0]   cnt_addr;
    logic [ADDR_W-1:0]   cnt_addr_m1;
    logic                cnt_nonzero;

    assign nk_last     = CNT_W'(nk_q);
    assign nq_last     = CNT_W'(nq_q);
    assign nk_rows     = nk_last + CNT_ONE;
    assign nq_rows     = nq_last + CNT_ONE;
    assign cnt_addr    = cnt_q[ADDR_W-1:0];
    // Address of the row whose read was issued one cycle earlier; only used
    // on cycles 1..N so the low-bit subtraction never underflows in use.
    assign cnt_addr_m1 = cnt_q[ADDR_W-1:0] - ADDR_ONE;
    assign cnt_nonzero = (cnt_q != '0);

    // ------------------------------------------------------------------------
    // State / output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            phase_q    <= 2'd0;
            nk_q       <= '0;
            nq_q       <= '0;
            inst_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            nk_q       <= nk_d;
            nq_q       <= nq_d;
            inst_q     <= inst_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic. Every word computed here is the one
    // the core sees on the following cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        nk_d       = nk_q;
        nq_d       = nq_q;
        inst_d     = '0;
        in_ready_d = 1'b0;
        busy_d     = (state_q != S_IDLE);
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                phase_d = 2'd0;
                // busy_q is still high on the cycle right after FIN, so a
                // start there is rejected like any other start-while-busy.
                if (start && !busy_q) begin
                    nk_d    = n_k;
                    nq_d    = n_q;
                    busy_d  = 1'b1;
                    state_d = S_WR_K;
                end
            end

            S_WR_K: begin
                // The address only advances on accepted words, so stalls
                // leave no holes in the K SRAM image.
                if (in_valid) begin
                    inst_d[B_KMEM_WR]               = 1'b1;
                    inst_d[B_QK_ADD +: ADDR_W]      = cnt_addr;
                    in_ready_d                      = 1'b1;
                    if (cnt_q == nk_last) begin
                        cnt_d   = '0;
                        state_d = S_WR_Q;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            S_WR_Q: begin
                if (in_valid) begin
                    inst_d[B_QMEM_WR]               = 1'b1;
                    inst_d[B_QK_ADD +: ADDR_W]      = cnt_addr;
                    in_ready_d                      = 1'b1;
                    if (cnt_q == nq_last) begin
                        cnt_d   = '0;
                        state_d = S_LD_K;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            S_LD_K: begin
                // kmem read on 0..NK-1, kernel-load one cycle behind it.
                if (cnt_q < nk_rows) begin
                    inst_d[B_KMEM_RD]               = 1'b1;
                    inst_d[B_QK_ADD +: ADDR_W]      = cnt_addr;
                end
                inst_d[B_LOAD] = cnt_nonzero;
                if (cnt_q == nk_rows) begin
                    cnt_d   = '0;
                    state_d = S_EXE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_EXE: begin
                if (cnt_q < nq_rows) begin
                    inst_d[B_QMEM_RD]               = 1'b1;
                    inst_d[B_QK_ADD +: ADDR_W]      = cnt_addr;
                end
                inst_d[B_EXECUTE] = cnt_nonzero;
                if (cnt_q == nq_rows) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DRAIN: begin
                // Idle bus while the last products ripple through the
                // array into the OFIFO.
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_OF;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_OF: begin
                // OFIFO data arrives one cycle after ofifo_rd and lands in
                // psum row c-1.
                if (cnt_q < nq_rows) begin
                    inst_d[B_OFIFO_RD] = 1'b1;
                end
                if (cnt_nonzero) begin
                    inst_d[B_PMEM_WR]               = 1'b1;
                    inst_d[B_P_ADD +: ADDR_W]       = cnt_addr_m1;
                end
                if (cnt_q == nq_rows) begin
                    cnt_d   = '0;
                    state_d = S_ACC;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_ACC: begin
                if (cnt_q < nq_rows) begin
                    inst_d[B_PMEM_RD]               = 1'b1;
                    inst_d[B_P_ADD +: ADDR_W]       = cnt_addr;
                end
                inst_d[B_SFP_ACC] = cnt_nonzero;
                if (cnt_q == nq_rows) begin
                    cnt_d   = '0;
                    phase_d = 2'd0;
                    state_d = S_DIV;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DIV: begin
                // Rows are not overlapped: read, divide, write back, then
                // the next row, so psum is never read and written together.
                case (phase_q)
                    2'd0: begin
                        inst_d[B_PMEM_RD]           = 1'b1;
                        inst_d[B_P_ADD +: ADDR_W]   = cnt_addr;
                        phase_d                     = 2'd1;
                    end
                    2'd1: begin
                        inst_d[B_SFP_DIV]           = 1'b1;
                        phase_d                     = 2'd2;
                    end
                    default: begin
                        inst_d[B_SFP_WR2PMEM]       = 1'b1;
                        inst_d[B_PMEM_WR]           = 1'b1;
                        inst_d[B_P_ADD +: ADDR_W]   = cnt_addr;
                        phase_d                     = 2'd0;
                        if (cnt_q == nq_last) begin
                            cnt_d   = '0;
                            state_d = S_FIN;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                endcase
            end

            S_FIN: begin
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                phase_d = 2'd0;
            end
        endcase
    end

    assign inst     = inst_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // ------------------------------------------------------------------------
    // Bus invariants
    // ------------------------------------------------------------------------
    a_pmem_excl: assert property (@(posedge clk) disable iff (!reset)
        !(inst_q[B_PMEM_RD] && inst_q[B_PMEM_WR]));

    a_qk_excl: assert property (@(posedge clk) disable iff (!reset)
        !((inst_q[B_QMEM_RD] || inst_q[B_QMEM_WR]) &&
          (inst_q[B_KMEM_RD] || inst_q[B_KMEM_WR])));

    a_ready_mirror: assert property (@(posedge clk) disable iff (!reset)
        in_ready_q == (inst_q[B_KMEM_WR] || inst_q[B_QMEM_WR]));

endmodule
`default_nettype wire

// File: tb/tb_npu_inst_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_npu_inst_seq
// Description : Directed self-checking bench for npu_inst_seq. Each scenario
//               task drives stimulus and compares the inst bus cycle by
//               cycle against words written out from the bit map.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_inst_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  n_k = 4'd0;
    logic [3:0]  n_q = 4'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] inst;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    npu_inst_seq #(.ADDR_W(4), .DRAIN(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .n_k      (n_k),
        .n_q      (n_q),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .inst     (inst),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete pass with per-cycle comparison of the inst word.
    task automatic run_pass(input int nk, input int nq, input bit stall, input bit poke);
        int          nkr;
        int          nqr;
        int          g;
        int          idx;
        int          cyc;
        int          lim;
        bit          v;
        logic [19:0] exp;
        nkr = nk + 1;
        nqr = nq + 1;
        g   = 0;
        cyc = 0;

        start = 1'b1;
        n_k   = 4'(nk);
        n_q   = 4'(nq);
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || inst !== 20'h0)
            $display("FAIL start_ack: busy=%b inst=%h expected busy=1 inst=00000", busy, inst);

        for (int ph = 0; ph < 2; ph++) begin
            idx = 0;
            lim = (ph == 0) ? nkr : nqr;
            while (idx < lim) begin
                v = stall ? (g % 3 == 0) : 1'b1;
                g++;
                in_valid = v;
                tick();
                cyc++;
                exp = v ? (((ph == 0) ? 20'h00004 : 20'h00010) | (20'(idx) << 12)) : 20'h0;
                checks++;
                if (inst !== exp || in_ready !== v) begin
                    errors++;
                    $display("FAIL wr%s idx=%0d: inst=%h in_ready=%b expected inst=%h in_ready=%b",
                             (ph == 0) ? "k" : "q", idx, inst, in_ready, exp, v);
                end
                if (v) idx++;
            end
        end
        in_valid = 1'b0;

        for (int c = 0; c <= nkr; c++) begin
            tick();
            cyc++;
            exp = ((c < nkr) ? (20'h00008 | (20'(c) << 12)) : 20'h0) | ((c >= 1) ? 20'h00040 : 20'h0);
            checks++;
            if (inst !== exp || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL ldk c=%0d: inst=%h in_ready=%b expected inst=%h in_ready=0", c, inst, in_ready, exp);
            end
        end

        for (int c = 0; c <= nqr; c++) begin
            tick();
            cyc++;
            exp = ((c < nqr) ? (20'h00020 | (20'(c) << 12)) : 20'h0) | ((c >= 1) ? 20'h00080 : 20'h0);
            checks++;
            if (inst !== exp) begin
                errors++;
                $display("FAIL exe c=%0d: inst=%h expected %h", c, inst, exp);
            end
        end

        for (int c = 0; c < 16; c++) begin
            tick();
            cyc++;
            checks++;
            if (inst !== 20'h0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL drain c=%0d: inst=%h busy=%b expected inst=00000 busy=1", c, inst, busy);
            end
        end

        for (int c = 0; c <= nqr; c++) begin
            tick();
            cyc++;
            exp = ((c < nqr) ? 20'h10000 : 20'h0) | ((c >= 1) ? (20'h00001 | (20'(c - 1) << 8)) : 20'h0);
            checks++;
            if (inst !== exp) begin
                errors++;
                $display("FAIL of c=%0d: inst=%h expected %h", c, inst, exp);
            end
        end

        for (int c = 0; c <= nqr; c++) begin
            if (poke && c == 2) begin
                start = 1'b1;
                n_q   = 4'(nq) ^ 4'hA;
                n_k   = 4'(nk) ^ 4'h5;
            end
            tick();
            cyc++;
            start = 1'b0;
            exp = ((c < nqr) ? (20'h00002 | (20'(c) << 8)) : 20'h0) | ((c >= 1) ? 20'h20000 : 20'h0);
            checks++;
            if (inst !== exp) begin
                errors++;
                $display("FAIL acc c=%0d: inst=%h expected %h", c, inst, exp);
            end
        end

        for (int r = 0; r < nqr; r++) begin
            for (int p = 0; p < 3; p++) begin
                tick();
                cyc++;
                case (p)
                    0:       exp = 20'h00002 | (20'(r) << 8);
                    1:       exp = 20'h40000;
                    default: exp = 20'h80001 | (20'(r) << 8);
                endcase
                checks++;
                if (inst !== exp || done !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL div r=%0d p=%0d: inst=%h done=%b busy=%b expected inst=%h done=0 busy=1",
                             r, p, inst, done, busy, exp);
                end
            end
        end

        tick();
        cyc++;
        checks++;
        if (inst !== 20'h0 || done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fin: inst=%h done=%b busy=%b expected inst=00000 done=1 busy=1", inst, done, busy);
        end
        if (!stall) begin
            // Cycles from the first WR_K word to the done word.
            checks++;
            if (cyc - 1 != 2 * nkr + 7 * nqr + 4 + 16) begin
                errors++;
                $display("FAIL pass_len: cycles=%0d expected %0d", cyc - 1, 2 * nkr + 7 * nqr + 4 + 16);
            end
        end

        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || inst !== 20'h0) begin
            errors++;
            $display("FAIL post_done: done=%b busy=%b inst=%h expected 0 0 00000", done, busy, inst);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        start    = 1'b1;
        n_k      = 4'd7;
        n_q      = 4'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (inst !== 20'h0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset cyc=%0d: inst=%h busy=%b done=%b in_ready=%b expected all 0",
                         i, inst, busy, done, in_ready);
            end
        end
        reset    = 1'b1;
        start    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (inst !== 20'h0 || busy !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_release cyc=%0d: inst=%h busy=%b in_ready=%b expected idle",
                         i, inst, busy, in_ready);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full_pass();
        run_pass(7, 7, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        run_pass(7, 7, 1'b1, 1'b0);
    endtask

    task automatic test_boundary();
        run_pass(0, 15, 1'b0, 1'b0);
        run_pass(15, 0, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        logic [19:0] exp;
        start    = 1'b1;
        n_k      = 4'd3;
        n_q      = 4'd3;
        in_valid = 1'b1;
        tick();
        start    = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (inst !== 20'h03010) begin
            errors++;
            $display("FAIL midrst_lastwr: inst=%h expected 03010", inst);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        for (int c = 0; c < 3; c++) begin
            tick();
            exp = 20'h00020 | (20'(c) << 12) | ((c >= 1) ? 20'h00080 : 20'h0);
            checks++;
            if (inst !== exp) begin
                errors++;
                $display("FAIL midrst_exe c=%0d: inst=%h expected %h", c, inst, exp);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if (inst !== 20'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: inst=%h busy=%b done=%b expected 00000 0 0", inst, busy, done);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (inst !== 20'h0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_idle cyc=%0d: inst=%h busy=%b expected 00000 0", i, inst, busy);
            end
        end
        run_pass(3, 3, 1'b0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_pass(3, 5, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || inst !== 20'h0) begin
                errors++;
                $display("FAIL busy_start_idle cyc=%0d: done=%b busy=%b inst=%h expected 0 0 00000",
                         i, done, busy, inst);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_stall();
        test_boundary();
        test_mid_reset();
        test_start_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
